// File: rtl/gpio_in_debounce_ahb.sv
// Debounced GPIO inputs with sticky edge flags, a level interrupt and an AHB-Lite slave port.
// Define GPIO_FALL_EDGE_EN to also latch falling edges in EDGE/IE bits [2*WIDTH-1:WIDTH].
module gpio_in_debounce_ahb #(
    parameter int unsigned WIDTH     = 3,
    parameter int unsigned DB_CYCLES = 48000,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic [WIDTH-1:0] pin_in,
    input  logic             HSEL,
    input  logic [7:0]       HADDR,
    input  logic [1:0]       HTRANS,
    input  logic             HWRITE,
    input  logic             HREADY,
    input  logic [31:0]      HWDATA,
    output logic [31:0]      HRDATA,
    output logic             HREADYOUT,
    output logic             HRESP,
    output logic             irq
);

`ifdef GPIO_FALL_EDGE_EN
    localparam int unsigned EW = 2 * WIDTH;
`else
    localparam int unsigned EW = WIDTH;
`endif

    localparam logic [CNT_W-1:0] DbLast   = CNT_W'(DB_CYCLES - 1);
    localparam logic [1:0]       AddrData = 2'd0;
    localparam logic [1:0]       AddrEdge = 2'd1;
    localparam logic [1:0]       AddrIe   = 2'd2;

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [EW-1:0]    edge_q, edge_d;
    logic [EW-1:0]    ie_q, ie_d;
    logic [1:0]       addr_q, addr_d;
    logic             write_q, write_d;
    logic             valid_q, valid_d;
    logic             irq_q, irq_d;
    logic             accept;
    logic             unused_bits;

    assign unused_bits = ^{HADDR[7:4], HADDR[1:0], HTRANS[0], HWDATA};

    // A level is accepted only after it differs from stable for DB_CYCLES consecutive cycles.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == DbLast) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign accept = HSEL & HTRANS[1] & HREADY;

    always_comb begin
        addr_d  = addr_q;
        write_d = write_q;
        valid_d = valid_q;
        if (accept) begin
            addr_d  = HADDR[3:2];
            write_d = HWRITE;
            valid_d = 1'b1;
        end else if (HREADY) begin
            valid_d = 1'b0;
        end
    end

    // W1C is applied first so that a same-cycle edge set overrides the clear.
    always_comb begin
        edge_d = edge_q;
        ie_d   = ie_q;
        if (valid_q && write_q) begin
            if (addr_q == AddrEdge) edge_d = edge_q & ~HWDATA[EW-1:0];
            if (addr_q == AddrIe)   ie_d   = HWDATA[EW-1:0];
        end
        edge_d[WIDTH-1:0] = edge_d[WIDTH-1:0] | (stable_d & ~stable_q);
`ifdef GPIO_FALL_EDGE_EN
        edge_d[EW-1:WIDTH] = edge_d[EW-1:WIDTH] | (stable_q & ~stable_d);
`endif
        irq_d = |(edge_q & ie_q);
    end

    always_comb begin
        HRDATA = '0;
        if (valid_q && !write_q) begin
            case (addr_q)
                AddrData: HRDATA[WIDTH-1:0] = stable_q;
                AddrEdge: HRDATA[EW-1:0]    = edge_q;
                AddrIe:   HRDATA[EW-1:0]    = ie_q;
                default:  HRDATA            = '0;
            endcase
        end
    end

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
    assign irq       = irq_q;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
            edge_q   <= '0;
            ie_q     <= '0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            valid_q  <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            sync1_q  <= pin_in;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
            edge_q   <= edge_d;
            ie_q     <= ie_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            valid_q  <= valid_d;
            irq_q    <= irq_d;
        end
    end

endmodule

// File: tb/tb_gpio_in_debounce_ahb.sv
// Self-checking bench for gpio_in_debounce_ahb (WIDTH=3, DB_CYCLES=4); expected values go
// through a scoreboard queue and are compared when the DUT output is sampled.
`timescale 1ns/1ps
module tb_gpio_in_debounce_ahb;
    localparam int unsigned WIDTH = 3;

`ifdef GPIO_FALL_EDGE_EN
    localparam bit FallEn = 1'b1;
`else
    localparam bit FallEn = 1'b0;
`endif

    logic             HCLK = 1'b0;
    logic             HRESET = 1'b1;
    logic [WIDTH-1:0] pin_in = '0;
    logic             HSEL = 1'b0;
    logic [7:0]       HADDR = '0;
    logic [1:0]       HTRANS = '0;
    logic             HWRITE = 1'b0;
    logic             HREADY = 1'b1;
    logic [31:0]      HWDATA = '0;
    logic [31:0]      HRDATA;
    logic             HREADYOUT;
    logic             HRESP;
    logic             irq;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_q[$];
    logic [31:0] got, exp;

    gpio_in_debounce_ahb #(
        .WIDTH     (WIDTH),
        .DB_CYCLES (4),
        .CNT_W     (16)
    ) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .pin_in    (pin_in),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HREADY    (HREADY),
        .HWDATA    (HWDATA),
        .HRDATA    (HRDATA),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .irq       (irq)
    );

    always #5 HCLK = ~HCLK;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic bus_write(input logic [7:0] addr, input logic [31:0] data);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = addr;
        tick();
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = data;
        tick();
    endtask

    task automatic bus_read(input logic [7:0] addr, output logic [31:0] data);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = addr;
        tick();
        data = HRDATA;
        HSEL = 1'b0; HTRANS = 2'b00;
        tick();
    endtask

    task automatic test_reset();
        HRESET = 1'b1;
        tick();
        tick();
        HRESET = 1'b0;
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++; $display("FAIL reset_irq: got %b expected 0", irq);
        end
        vectors++;
        if (HREADYOUT !== 1'b1) begin
            miscompares++; $display("FAIL reset_hreadyout: got %b expected 1", HREADYOUT);
        end
        vectors++;
        if (HRESP !== 1'b0) begin
            miscompares++; $display("FAIL reset_hresp: got %b expected 0", HRESP);
        end
        vectors++;
        if (HRDATA !== 32'h0) begin
            miscompares++; $display("FAIL reset_hrdata: got %h expected 0", HRDATA);
        end
        for (int a = 0; a < 3; a++) begin
            exp_q.push_back(32'h0);
            bus_read(8'(a * 4), got);
            exp = exp_q.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL reset_reg%0d: got %h expected %h", a, got, exp);
            end
        end
    endtask

    task automatic test_glitch();
        pin_in[0] = 1'b1;
        repeat (3) tick();
        pin_in[0] = 1'b0;
        repeat (10) tick();
        exp_q.push_back(32'h0);
        bus_read(8'h00, got);
        exp = exp_q.pop_front();
        vectors++;
        if (got !== exp) begin
            miscompares++; $display("FAIL glitch_data: got %h expected %h", got, exp);
        end
        exp_q.push_back(32'h0);
        bus_read(8'h04, got);
        exp = exp_q.pop_front();
        vectors++;
        if (got !== exp) begin
            miscompares++; $display("FAIL glitch_edge: got %h expected %h", got, exp);
        end
    endtask

    // Streams DATA reads every cycle so the exact cycle stable updates is visible.
    task automatic test_debounce_accept();
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 8'h00;
        tick();
        pin_in[0] = 1'b1;
        for (int n = 1; n <= 8; n++) exp_q.push_back((n >= 6) ? 32'h1 : 32'h0);
        for (int n = 1; n <= 8; n++) begin
            tick();
            exp = exp_q.pop_front();
            vectors++;
            if (HRDATA !== exp) begin
                miscompares++;
                $display("FAIL accept_data_cycle%0d: got %h expected %h", n, HRDATA, exp);
            end
        end
        HSEL = 1'b0; HTRANS = 2'b00;
        tick();
        exp_q.push_back(32'h1);
        bus_read(8'h04, got);
        exp = exp_q.pop_front();
        vectors++;
        if (got !== exp) begin
            miscompares++; $display("FAIL accept_edge: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_irq_w1c();
        bus_write(8'h08, 32'h1);
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++; $display("FAIL irq_before_delay: got %b expected 0", irq);
        end
        tick();
        vectors++;
        if (irq !== 1'b1) begin
            miscompares++; $display("FAIL irq_after_ie: got %b expected 1", irq);
        end
        bus_write(8'h04, 32'h0);
        exp_q.push_back(32'h1);
        bus_read(8'h04, got);
        exp = exp_q.pop_front();
        vectors++;
        if (got !== exp) begin
            miscompares++; $display("FAIL w1c_zero_edge: got %h expected %h", got, exp);
        end
        vectors++;
        if (irq !== 1'b1) begin
            miscompares++; $display("FAIL w1c_zero_irq: got %b expected 1", irq);
        end
        bus_write(8'h04, 32'h1);
        tick();
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++; $display("FAIL w1c_irq_clear: got %b expected 0", irq);
        end
        exp_q.push_back(32'h0);
        bus_read(8'h04, got);
        exp = exp_q.pop_front();
        vectors++;
        if (got !== exp) begin
            miscompares++; $display("FAIL w1c_edge_clear: got %h expected %h", got, exp);
        end
    endtask

    // The W1C data phase lands on the same edge at which stable[1] rises.
    task automatic test_collision();
        pin_in[1] = 1'b1;
        repeat (4) tick();
        bus_write(8'h04, 32'h2);
        exp_q.push_back(32'h2);
        bus_read(8'h04, got);
        exp = exp_q.pop_front();
        vectors++;
        if (got !== exp) begin
            miscompares++; $display("FAIL collision_edge: got %h expected %h", got, exp);
        end
        exp_q.push_back(32'h3);
        bus_read(8'h00, got);
        exp = exp_q.pop_front();
        vectors++;
        if (got !== exp) begin
            miscompares++; $display("FAIL collision_data: got %h expected %h", got, exp);
        end
        bus_write(8'h04, 32'h2);
        exp_q.push_back(32'h0);
        bus_read(8'h04, got);
        exp = exp_q.pop_front();
        vectors++;
        if (got !== exp) begin
            miscompares++; $display("FAIL collision_reclear: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_back_to_back();
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 8'h08;
        tick();
        HWDATA = 32'h7; HWRITE = 1'b0; HADDR = 8'h08;
        exp_q.push_back(32'h7);
        tick();
        exp = exp_q.pop_front();
        vectors++;
        if (HRDATA !== exp) begin
            miscompares++; $display("FAIL b2b_read_ie: got %h expected %h", HRDATA, exp);
        end
        vectors++;
        if (HREADYOUT !== 1'b1) begin
            miscompares++; $display("FAIL b2b_hreadyout: got %b expected 1", HREADYOUT);
        end
        HSEL = 1'b0; HTRANS = 2'b00;
        tick();
        // Write IE=0 with HSEL low, then with HTRANS IDLE; neither may land.
        HSEL = 1'b0; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 8'h08;
        tick();
        HWDATA = 32'h0; HTRANS = 2'b00; HWRITE = 1'b0;
        tick();
        exp_q.push_back(32'h7);
        bus_read(8'h08, got);
        exp = exp_q.pop_front();
        vectors++;
        if (got !== exp) begin
            miscompares++; $display("FAIL hsel_low_write: got %h expected %h", got, exp);
        end
        HSEL = 1'b1; HTRANS = 2'b00; HWRITE = 1'b1; HADDR = 8'h08;
        tick();
        HSEL = 1'b0; HWDATA = 32'h0; HWRITE = 1'b0;
        tick();
        exp_q.push_back(32'h7);
        bus_read(8'h08, got);
        exp = exp_q.pop_front();
        vectors++;
        if (got !== exp) begin
            miscompares++; $display("FAIL idle_write: got %h expected %h", got, exp);
        end
        bus_write(8'h0C, 32'hFFFF_FFFF);
        exp_q.push_back(32'h0);
        bus_read(8'h0C, got);
        exp = exp_q.pop_front();
        vectors++;
        if (got !== exp) begin
            miscompares++; $display("FAIL reserved_raz: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_fall_edge();
        pin_in[2] = 1'b1;
        repeat (10) tick();
        bus_write(8'h04, 32'h4);
        exp_q.push_back(32'h0);
        bus_read(8'h04, got);
        exp = exp_q.pop_front();
        vectors++;
        if (got !== exp) begin
            miscompares++; $display("FAIL fall_pre_edge: got %h expected %h", got, exp);
        end
        pin_in[2] = 1'b0;
        repeat (10) tick();
        exp_q.push_back(FallEn ? 32'h20 : 32'h0);
        bus_read(8'h04, got);
        exp = exp_q.pop_front();
        vectors++;
        if (got !== exp) begin
            miscompares++; $display("FAIL fall_edge: got %h expected %h", got, exp);
        end
        bus_write(8'h08, 32'h3F);
        exp_q.push_back(FallEn ? 32'h3F : 32'h07);
        bus_read(8'h08, got);
        exp = exp_q.pop_front();
        vectors++;
        if (got !== exp) begin
            miscompares++; $display("FAIL fall_ie_width: got %h expected %h", got, exp);
        end
        tick();
        vectors++;
        if (irq !== FallEn) begin
            miscompares++; $display("FAIL fall_irq: got %b expected %b", irq, FallEn);
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_debounce_accept();
        test_irq_w1c();
        test_collision();
        test_back_to_back();
        test_fall_edge();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
